timer_alarm_sched: RTL

//  Multi-channel alarm scheduler on the free-running 64-bit timer value.

---
 rtl/timer_alarm_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/timer_alarm_sched.sv
// Multi-channel alarm scheduler: a single shared comparator visits armed channels round-robin
// and latches expired deadlines into pending bits, which are ORed into a registered interrupt.
module timer_alarm_sched #(
    parameter int unsigned N_ALARM = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   timer_value,
    input  logic               arm_valid,
    input  logic [ID_W-1:0]    arm_id,
    input  logic [CNT_W-1:0]   arm_deadline,
    input  logic               disarm_valid,
    input  logic [ID_W-1:0]    disarm_id,
    input  logic               ack_valid,
    input  logic [ID_W-1:0]    ack_id,
    output logic [N_ALARM-1:0] armed,
    output logic [N_ALARM-1:0] pending,
    output logic               irq,
    output logic [ID_W-1:0]    scan_ptr
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e             state_q, state_d;
    logic [N_ALARM-1:0] armed_q, armed_d;
    logic [N_ALARM-1:0] pending_q, pending_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    scan_ptr_q, scan_ptr_d;
    logic [CNT_W-1:0]   deadline_q [N_ALARM];
    logic [CNT_W-1:0]   deadline_d [N_ALARM];

    // One-hot decodes; an index >= N_ALARM matches no channel and is thereby ignored.
    logic [N_ALARM-1:0] arm_sel, disarm_sel, ack_sel, scan_sel, expire_sel;
    logic [CNT_W-1:0]   cur_deadline;
    logic               cur_armed;
    logic [CNT_W-1:0]   diff;
    logic               expire_hit;

    always_comb begin
        arm_sel      = '0;
        disarm_sel   = '0;
        ack_sel      = '0;
        scan_sel     = '0;
        cur_deadline = '0;
        cur_armed    = 1'b0;
        for (int unsigned i = 0; i < N_ALARM; i++) begin
            arm_sel[i]    = arm_valid && (arm_id == ID_W'(i));
            disarm_sel[i] = disarm_valid && (disarm_id == ID_W'(i));
            ack_sel[i]    = ack_valid && (ack_id == ID_W'(i));
            scan_sel[i]   = (scan_ptr_q == ID_W'(i));
            if (scan_sel[i]) begin
                cur_deadline = deadline_q[i];
                cur_armed    = armed_q[i];
            end
        end
    end

    // Modular difference: MSB clear means timer_value has reached the deadline, across wrap.
    assign diff       = timer_value - cur_deadline;
    assign expire_hit = (state_q == StScan) && cur_armed && !diff[CNT_W-1];

    // A same-cycle arm on the scanned channel overrides its expiry.
    assign expire_sel = scan_sel & {N_ALARM{expire_hit}} & ~arm_sel;

    always_comb begin
        armed_d   = (armed_q & ~expire_sel & ~disarm_sel) | arm_sel;
        pending_d = (pending_q & ~ack_sel) | expire_sel;
        irq_d     = |pending_q;
        for (int unsigned i = 0; i < N_ALARM; i++) begin
            deadline_d[i] = arm_sel[i] ? arm_deadline : deadline_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        scan_ptr_d = scan_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|armed_q) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (armed_q == '0) begin
                    state_d = StIdle;
                end else if (scan_ptr_q == ID_W'(N_ALARM - 1)) begin
                    scan_ptr_d = '0;
                end else begin
                    scan_ptr_d = scan_ptr_q + ID_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            armed_q    <= '0;
            pending_q  <= '0;
            irq_q      <= 1'b0;
            scan_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
            scan_ptr_q <= scan_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_ALARM; i++) begin
                deadline_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_ALARM; i++) begin
                deadline_q[i] <= deadline_d[i];
            end
        end
    end

    assign armed    = armed_q;
    assign pending  = pending_q;
    assign irq      = irq_q;
    assign scan_ptr = scan_ptr_q;

endmodule
